pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. It takes hazard information from DC, EX and MEM, plus the data-memory handshake, and drives the hold (`*_stay`) and bubble (`*_flush`) controls of the PC register and the IF/DC, DC/EX, EX/MEM and MEM/WB pipeline registers. It also keeps stall and flush performance counters.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 16: maximum number of MEM_WAIT cycles before the access is abandoned. Only used with `PIPE_CTRL_TIMEOUT_EN`; legal range 2..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dc_rs1`, `dc_rs2`  in  5 each  source registers of the instruction in DC.
- `dc_use_rs1`, `dc_use_rs2`  in  1 each  DC instruction actually reads rs1/rs2.
- `ex_is_load`  in  1  instruction in EX is a load.
- `ex_rd`  in  5  destination register of the EX instruction.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump.
- `mem_req`  in  1  MEM stage has an outstanding data access.
- `mem_ack`  in  1  data memory completes the access this cycle.
- `pc_stay`, `if_dc_stay`, `dc_ex_stay`, `ex_mem_stay`  out  1 each  hold the register.
- `if_dc_flush`, `dc_ex_flush`, `mem_wb_flush`  out  1 each  load a NOP bubble into the register.
- `pc_sel_branch`  out  1  PC loads the EX branch target.
- `mem_timeout`  out  1  one-cycle pulse when an access is abandoned.
- `stall_cycles`  out  32  count of cycles with `pc_stay` = 1.
- `flush_count`  out  16  count of branch flushes.

## Operation
- FSM states: RUN and MEM_WAIT. Control outputs are combinational from the current state and the current inputs. State and counters are registered.
- Load-use hazard: `ex_is_load && ex_rd != 0 && ((dc_use_rs1 && dc_rs1 == ex_rd) || (dc_use_rs2 && dc_rs2 == ex_rd))`.
- Priority inside RUN is memory stall, then branch, then load-use.
- **RUN, `mem_req && !mem_ack`:**
  - `pc_stay`, `if_dc_stay`, `dc_ex_stay`, `ex_mem_stay` = 1; `mem_wb_flush` = 1.
  - Branch and load-use outputs are suppressed.
  - Next state is MEM_WAIT; `wait_cnt` is set to 0.
- **RUN, branch taken and no memory stall:**
  - `pc_sel_branch`, `if_dc_flush`, `dc_ex_flush` = 1 for exactly that cycle.
  - `flush_count` += 1.
  - The load-use stall is ignored, because the DC instruction is being squashed.
- **RUN, load-use only:** `pc_stay`, `if_dc_stay`, `dc_ex_flush` = 1. The hazard clears on its own the next cycle, once the load has advanced.
- **RUN, nothing asserted:** all control outputs are 0.
- **MEM_WAIT, `!mem_ack`:** same holds as entering the stall; `wait_cnt` += 1.
- **MEM_WAIT, `mem_ack`:** all holds drop in that same cycle; next state is RUN. A branch or load-use present in that cycle is evaluated as in RUN.
- **Branch during MEM_WAIT:** the EX/MEM holds keep the branch instruction in EX, so it is acted on in the first RUN cycle.
- **Counters:**
  - `stall_cycles` increments every cycle `pc_stay` = 1 and wraps at 2^32.
  - `flush_count` wraps at 2^16.

## Timing
- Reset (`reset` = 1 at a rising edge):
  - State becomes RUN; `wait_cnt`, `stall_cycles` and `flush_count` become 0.
  - While `reset` is high, all `*_stay` = 1, all `*_flush` = 0, `pc_sel_branch` = 0, `mem_timeout` = 0.
- Reset during MEM_WAIT abandons the access with no `mem_timeout` pulse.
- Control outputs have zero latency: they react in the same cycle the inputs change.
- Counters update one edge after the qualifying cycle.
- `mem_req` and `mem_ack` together in RUN count as a zero-wait access: no stall, no state change.
- `mem_ack` without `mem_req` in RUN is ignored.
- A wait of N cycles gives N cycles of holds; the ack cycle itself is not held.

## Configuration
- Macro: `PIPE_CTRL_TIMEOUT_EN`.
- **Defined:** in MEM_WAIT, when `wait_cnt == MEM_TIMEOUT-1` and `!mem_ack`:
  - `mem_timeout` = 1 for that cycle.
  - Holds drop as if `mem_ack` had arrived.
  - Next state is RUN.
  - `mem_ack` in that same cycle takes precedence: no pulse.
- **Undefined:** MEM_WAIT lasts until `mem_ack`, with no limit; `mem_timeout` is tied to 0 and `wait_cnt` is not built.

## Test plan
- **Load-use:** `ex_is_load` = 1, `ex_rd` = 5, `dc_use_rs2` = 1, `dc_rs2` = 5 for one cycle -> `pc_stay` = `if_dc_stay` = `dc_ex_flush` = 1 for that cycle, `stall_cycles` = 1 after it. Repeat with `ex_rd` = 0 -> no stall.
- **Branch vs load-use:** `ex_branch_taken` = 1 together with a load-use match -> `pc_sel_branch` = `if_dc_flush` = `dc_ex_flush` = 1, `pc_stay` = 0, `flush_count` = 1.
- **3-wait access:** `mem_req` = 1 from cycle 0, `mem_ack` = 1 at cycle 3 -> holds and `mem_wb_flush` = 1 in cycles 0-2, all 0 in cycle 3, `stall_cycles` = 3. Zero-wait access (req and ack in the same cycle) -> no holds.
- **Branch held by a memory stall:** `ex_branch_taken` = 1 during a 2-cycle MEM_WAIT -> `pc_sel_branch` = 0 while waiting, then 1 in the ack cycle.
- **Timeout** (`PIPE_CTRL_TIMEOUT_EN`, `MEM_TIMEOUT` = 4), `mem_req` held with no ack:
  - `mem_timeout` pulses exactly once, in cycle 4.
  - Holds drop in that cycle; state returns to RUN.
  - With the macro undefined -> holds persist 100+ cycles and `mem_timeout` stays 0.
- **Reset in MEM_WAIT:** `reset` asserted in wait cycle 2 -> state RUN, counters 0, all stays 1 while reset is high, no `mem_timeout` pulse.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage RV32 pipeline. Combines the
// data-memory handshake, taken branches from EX and load-use hazards between
// EX and DC into hold (*_stay) and bubble (*_flush) controls. It also keeps
// stall-cycle and branch-flush performance counters.
//
// Optional feature macro: PIPE_CTRL_TIMEOUT_EN
//   defined   -> a MEM_WAIT that lasts MEM_TIMEOUT cycles without an ack is
//                abandoned and mem_timeout pulses for one cycle.
//   undefined -> MEM_WAIT lasts until mem_ack; mem_timeout is constant 0.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  dc_rs1,
    input  logic [4:0]  dc_rs2,
    input  logic        dc_use_rs1,
    input  logic        dc_use_rs2,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_stay,
    output logic        if_dc_stay,
    output logic        dc_ex_stay,
    output logic        ex_mem_stay,
    output logic        if_dc_flush,
    output logic        dc_ex_flush,
    output logic        mem_wb_flush,
    output logic        pc_sel_branch,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] stall_cycles_reg;
    logic [15:0] flush_count_reg;

    // Both DC source operands are checked against the EX destination the same way.
    logic [4:0] src_rs [2];
    logic [1:0] src_use;
    logic [1:0] src_hit;

    assign src_rs[0]  = dc_rs1;
    assign src_rs[1]  = dc_rs2;
    assign src_use[0] = dc_use_rs1;
    assign src_use[1] = dc_use_rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_rs[gi] == ex_rd);
        end
    endgenerate

    logic load_use;
    assign load_use = ex_is_load && (ex_rd != 5'd0) && (|src_hit);

    // timeout_hit: the current wait cycle is the last one allowed and no ack came.
    logic timeout_hit;
    logic mem_stall;

`ifdef PIPE_CTRL_TIMEOUT_EN
    logic [7:0] wait_cnt_reg;
    logic [7:0] wait_cnt_next;

    assign timeout_hit = (state_reg == ST_MEM_WAIT) && !mem_ack
                         && (wait_cnt_reg == 8'(MEM_TIMEOUT - 1));

    // Counter restarts on the cycle the stall begins and advances on each further wait cycle.
    always_comb begin
        wait_cnt_next = (state_reg == ST_RUN) ? 8'd0 : wait_cnt_reg + 8'd1;
    end

    // Wait counter only moves while the access is actually being held.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= 8'd0;
        end else if (mem_stall) begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`else
    // No wait limit in this build. MEM_TIMEOUT is never 0 in its legal
    // range (2..255), so this is a constant 0.
    assign timeout_hit = (MEM_TIMEOUT == 0);
`endif

    // A memory stall is a fresh unacked request in RUN, or a still-unacked wait.
    always_comb begin
        mem_stall = 1'b0;
        if (state_reg == ST_RUN) begin
            mem_stall = mem_req && !mem_ack;
        end else begin
            mem_stall = !mem_ack && !timeout_hit;
        end
        state_next = mem_stall ? ST_MEM_WAIT : ST_RUN;
    end

    // Priority: reset, memory stall, branch, load-use. A branch squashes the
    // DC instruction, so its load-use hazard no longer matters.
    logic branch_act;
    logic lu_act;

    assign branch_act = !reset && !mem_stall && ex_branch_taken;
    assign lu_act     = !reset && !mem_stall && !ex_branch_taken && load_use;

    assign pc_stay       = reset || mem_stall || lu_act;
    assign if_dc_stay    = reset || mem_stall || lu_act;
    assign dc_ex_stay    = reset || mem_stall;
    assign ex_mem_stay   = reset || mem_stall;
    assign if_dc_flush   = branch_act;
    assign dc_ex_flush   = branch_act || lu_act;
    assign mem_wb_flush  = !reset && mem_stall;
    assign pc_sel_branch = branch_act;
    assign mem_timeout   = !reset && timeout_hit;

    // State and performance counters; counters reflect the previous cycle's controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_RUN;
            stall_cycles_reg <= 32'd0;
            flush_count_reg  <= 16'd0;
        end else begin
            state_reg <= state_next;
            if (pc_stay) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (branch_act) begin
                flush_count_reg <= flush_count_reg + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the stall/flush rules.
// The timeout scenario follows PIPE_CTRL_TIMEOUT_EN the same way the design does.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int TMO = 4;
`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    // Control vector bit order:
    // pc_stay, if_dc_stay, dc_ex_stay, ex_mem_stay, if_dc_flush, dc_ex_flush,
    // mem_wb_flush, pc_sel_branch, mem_timeout
    localparam logic [8:0] C_IDLE  = 9'b000000000;
    localparam logic [8:0] C_RESET = 9'b111100000;
    localparam logic [8:0] C_LU    = 9'b110001000;
    localparam logic [8:0] C_BR    = 9'b000011010;
    localparam logic [8:0] C_MEM   = 9'b111100100;
    localparam logic [8:0] C_TO    = 9'b000000001;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  dc_rs1, dc_rs2, ex_rd;
    logic        dc_use_rs1, dc_use_rs2, ex_is_load, ex_branch_taken;
    logic        mem_req, mem_ack;
    logic        pc_stay, if_dc_stay, dc_ex_stay, ex_mem_stay;
    logic        if_dc_flush, dc_ex_flush, mem_wb_flush, pc_sel_branch, mem_timeout;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic [8:0]  ctl;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_in_access = 1'b0;
    int          m_held      = 0;
    logic [31:0] m_stall     = 32'd0;
    logic [15:0] m_flush     = 16'd0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .dc_rs1(dc_rs1), .dc_rs2(dc_rs2),
        .dc_use_rs1(dc_use_rs1), .dc_use_rs2(dc_use_rs2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_stay(pc_stay), .if_dc_stay(if_dc_stay),
        .dc_ex_stay(dc_ex_stay), .ex_mem_stay(ex_mem_stay),
        .if_dc_flush(if_dc_flush), .dc_ex_flush(dc_ex_flush),
        .mem_wb_flush(mem_wb_flush), .pc_sel_branch(pc_sel_branch),
        .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    assign ctl = {pc_stay, if_dc_stay, dc_ex_stay, ex_mem_stay,
                  if_dc_flush, dc_ex_flush, mem_wb_flush, pc_sel_branch, mem_timeout};

    // ---------------- reference model ----------------
    function automatic bit model_load_use();
        return ex_is_load && (ex_rd != 5'd0) &&
               ((dc_use_rs1 && dc_rs1 == ex_rd) || (dc_use_rs2 && dc_rs2 == ex_rd));
    endfunction

    // An access is given up once it has already been held for TMO cycles.
    function automatic bit model_timeout();
        return TIMEOUT_EN && m_in_access && !mem_ack && (m_held == TMO);
    endfunction

    function automatic bit model_mem_hold();
        if (!m_in_access) return mem_req && !mem_ack;
        if (mem_ack) return 1'b0;
        if (model_timeout()) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [8:0] model_ctl();
        logic [8:0] r;
        if (reset) return C_RESET;
        if (model_mem_hold()) return C_MEM;
        r = C_IDLE;
        if (model_timeout()) r = r | C_TO;
        if (ex_branch_taken) r = r | C_BR;
        else if (model_load_use()) r = r | C_LU;
        return r;
    endfunction

    // Advance one clock, updating the model from the inputs of the closing cycle.
    task automatic tick();
        logic [8:0] e;
        bit hold;
        e    = model_ctl();
        hold = model_mem_hold();
        if (reset) begin
            m_in_access = 1'b0; m_held = 0; m_stall = 32'd0; m_flush = 16'd0;
        end else begin
            if (e[8]) m_stall = m_stall + 32'd1;
            if (e[1]) m_flush = m_flush + 16'd1;
            if (hold) begin m_in_access = 1'b1; m_held++; end
            else begin m_in_access = 1'b0; m_held = 0; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic ld,
                         input logic [4:0] rd, input logic br,
                         input logic req, input logic ack);
        dc_rs1 = rs1; dc_rs2 = rs2; dc_use_rs1 = u1; dc_use_rs2 = u2;
        ex_is_load = ld; ex_rd = rd; ex_branch_taken = br;
        mem_req = req; mem_ack = ack;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
        settle();
        checks++;
        if (ctl !== C_RESET) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RESET); end
        tick(); tick();
        reset = 1'b0;
        idle();
        settle();
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL reset_idle_ctl: got %b want %b", ctl, C_IDLE); end
        checks++;
        if (stall_cycles !== 32'd0 || flush_count !== 16'd0) begin
            errors++; $display("FAIL reset_counters: got stall=%0d flush=%0d want 0 0", stall_cycles, flush_count);
        end
        $display("test_reset: ctl=%b stall=%0d flush=%0d", ctl, stall_cycles, flush_count);
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        settle();
        checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL load_use_rs2: got %b want %b", ctl, C_LU); end
        tick();
        idle();
        settle();
        checks++;
        if (stall_cycles !== 32'd1) begin errors++; $display("FAIL load_use_stall: got %0d want 1", stall_cycles); end
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL load_use_clear: got %b want %b", ctl, C_IDLE); end
        drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        settle();
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL load_use_x0: got %b want %b", ctl, C_IDLE); end
        tick();
        drive(5'd7, 5'd1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        settle();
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL load_use_unused_rs1: got %b want %b", ctl, C_IDLE); end
        tick();
        drive(5'd7, 5'd1, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        settle();
        checks++;
        if (ctl !== C_LU) begin errors++; $display("FAIL load_use_rs1: got %b want %b", ctl, C_LU); end
        tick();
        idle();
        settle();
        checks++;
        if (stall_cycles !== 32'd2) begin errors++; $display("FAIL load_use_stall2: got %0d want 2", stall_cycles); end
        $display("test_load_use: stall=%0d", stall_cycles);
    endtask

    task automatic test_branch();
        apply_reset();
        drive(5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        settle();
        checks++;
        if (ctl !== C_BR) begin errors++; $display("FAIL branch_over_lu: got %b want %b", ctl, C_BR); end
        tick();
        idle();
        settle();
        checks++;
        if (flush_count !== 16'd1 || stall_cycles !== 32'd0) begin
            errors++; $display("FAIL branch_counters: got flush=%0d stall=%0d want 1 0", flush_count, stall_cycles);
        end
        $display("test_branch: flush=%0d stall=%0d", flush_count, stall_cycles);
    endtask

    task automatic test_mem_wait();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            settle();
            checks++;
            if (ctl !== C_MEM) begin errors++; $display("FAIL mem_wait_hold%0d: got %b want %b", k, ctl, C_MEM); end
            tick();
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        settle();
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL mem_wait_ack: got %b want %b", ctl, C_IDLE); end
        tick();
        idle();
        settle();
        checks++;
        if (stall_cycles !== 32'd3) begin errors++; $display("FAIL mem_wait_stall: got %0d want 3", stall_cycles); end
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL mem_wait_back_run: got %b want %b", ctl, C_IDLE); end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        settle();
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL zero_wait: got %b want %b", ctl, C_IDLE); end
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        settle();
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL ack_no_req: got %b want %b", ctl, C_IDLE); end
        tick();
        idle();
        settle();
        checks++;
        if (stall_cycles !== 32'd3) begin errors++; $display("FAIL zero_wait_stall: got %0d want 3", stall_cycles); end
        $display("test_mem_wait: stall=%0d", stall_cycles);
    endtask

    task automatic test_branch_held();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
            settle();
            checks++;
            if (ctl !== C_MEM) begin errors++; $display("FAIL branch_held_wait%0d: got %b want %b", k, ctl, C_MEM); end
            tick();
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        settle();
        checks++;
        if (ctl !== C_BR) begin errors++; $display("FAIL branch_held_ack: got %b want %b", ctl, C_BR); end
        tick();
        idle();
        settle();
        checks++;
        if (flush_count !== 16'd1 || stall_cycles !== 32'd2) begin
            errors++; $display("FAIL branch_held_counters: got flush=%0d stall=%0d want 1 2", flush_count, stall_cycles);
        end
        $display("test_branch_held: flush=%0d stall=%0d", flush_count, stall_cycles);
    endtask

    task automatic test_mem_timeout();
        int pulses;
        int held;
        logic [8:0] want;
        pulses = 0;
        held = 0;
        apply_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
`ifdef PIPE_CTRL_TIMEOUT_EN
        for (int k = 0; k < 9; k++) begin
            settle();
            want = (k == TMO) ? C_TO : C_MEM;
            checks++;
            if (ctl !== want) begin errors++; $display("FAIL timeout_cycle%0d: got %b want %b", k, ctl, want); end
            if (mem_timeout === 1'b1) pulses++;
            tick();
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL timeout_pulses: got %0d want 1", pulses); end
        idle();
        settle();
        checks++;
        if (stall_cycles !== 32'd8) begin errors++; $display("FAIL timeout_stall: got %0d want 8", stall_cycles); end
`else
        want = C_MEM;
        for (int k = 0; k < 110; k++) begin
            settle();
            if (mem_timeout === 1'b1) pulses++;
            if (pc_stay === 1'b1) held++;
            checks++;
            if (ctl !== want) begin errors++; $display("FAIL no_timeout_cycle%0d: got %b want %b", k, ctl, want); end
            tick();
        end
        checks++;
        if (pulses != 0 || held != 110) begin
            errors++; $display("FAIL no_timeout_summary: got pulses=%0d held=%0d want 0 110", pulses, held);
        end
        checks++;
        if (stall_cycles !== 32'd110) begin errors++; $display("FAIL no_timeout_stall: got %0d want 110", stall_cycles); end
        idle();
`endif
        $display("test_mem_timeout: pulses=%0d stall=%0d", pulses, stall_cycles);
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            settle();
            checks++;
            if (ctl !== C_MEM) begin errors++; $display("FAIL rst_wait_hold%0d: got %b want %b", k, ctl, C_MEM); end
            tick();
        end
        reset = 1'b1;
        settle();
        checks++;
        if (ctl !== C_RESET) begin errors++; $display("FAIL rst_wait_ctl: got %b want %b", ctl, C_RESET); end
        tick();
        reset = 1'b0;
        idle();
        settle();
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL rst_wait_run: got %b want %b", ctl, C_IDLE); end
        checks++;
        if (stall_cycles !== 32'd0 || flush_count !== 16'd0) begin
            errors++; $display("FAIL rst_wait_counters: got stall=%0d flush=%0d want 0 0", stall_cycles, flush_count);
        end
        $display("test_reset_in_wait: ctl=%b stall=%0d", ctl, stall_cycles);
    endtask

    task automatic test_random();
        logic [8:0] want;
        apply_reset();
        for (int k = 0; k < 300; k++) begin
            reset = ($urandom_range(99) < 3);
            dc_rs1 = 5'($urandom_range(3));
            dc_rs2 = 5'($urandom_range(3));
            ex_rd  = 5'($urandom_range(3));
            dc_use_rs1 = ($urandom_range(99) < 60);
            dc_use_rs2 = ($urandom_range(99) < 60);
            ex_is_load = ($urandom_range(99) < 40);
            ex_branch_taken = ($urandom_range(99) < 15);
            mem_req = ($urandom_range(99) < 30);
            mem_ack = ($urandom_range(99) < 35);
            settle();
            want = model_ctl();
            checks++;
            if (ctl !== want) begin errors++; $display("FAIL rand_ctl%0d: got %b want %b", k, ctl, want); end
            checks++;
            if (stall_cycles !== m_stall) begin errors++; $display("FAIL rand_stall%0d: got %0d want %0d", k, stall_cycles, m_stall); end
            checks++;
            if (flush_count !== m_flush) begin errors++; $display("FAIL rand_flush%0d: got %0d want %0d", k, flush_count, m_flush); end
            $display("rand %0d: rst=%b req=%b ack=%b br=%b lu=%b ctl=%b stall=%0d flush=%0d",
                     k, reset, mem_req, mem_ack, ex_branch_taken, model_load_use(), ctl, stall_cycles, flush_count);
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_branch_held();
        test_mem_timeout();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
